// File: rtl/ili9341_pkg.sv
// ili9341_pkg: shared panel constants, RGB565 type, FSM states and coordinate width helper.
package ili9341_pkg;
    localparam int PANEL_WIDTH = 240;
    localparam int PANEL_HEIGHT = 320;
    typedef logic [15:0] rgb565_t;
    localparam rgb565_t TRANSPARENT_565 = 16'hF81F;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
    function automatic int coord_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y raster position with advance enable and last-pixel flag.
module raster_counter
    import ili9341_pkg::*;
#(
    parameter int WIDTH = PANEL_WIDTH,
    parameter int HEIGHT = PANEL_HEIGHT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        advance,
    output logic [coord_w(WIDTH)-1:0]   x,
    output logic [coord_w(HEIGHT)-1:0]  y,
    output logic                        last
);
    localparam int XW = coord_w(WIDTH);
    localparam int YW = coord_w(HEIGHT);
    logic x_end;
    assign x_end = x == XW'(WIDTH - 1);
    assign last = x_end && y == YW'(HEIGHT - 1);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            x <= x_end ? '0 : x + 1'b1;
            y <= x_end ? (last ? '0 : y + 1'b1) : y;
        end
    end
endmodule

// File: rtl/sprite_pixel_source.sv
// sprite_pixel_source: raster-order RGB565 pixel generator composing a latched
// background with one scaled sprite read from an external one-cycle ROM.
module sprite_pixel_source
    import ili9341_pkg::*;
#(
    parameter int WIDTH = PANEL_WIDTH,
    parameter int HEIGHT = PANEL_HEIGHT,
    parameter int PIXEL_SIZE = 16,
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int SCALE_LOG2 = 2,
    parameter logic [PIXEL_SIZE-1:0] TRANSPARENT = TRANSPARENT_565
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic [PIXEL_SIZE-1:0]             bg_color,
    input  logic [coord_w(WIDTH)-1:0]         spr_x,
    input  logic [coord_w(HEIGHT)-1:0]        spr_y,
    input  logic                              pixel_req,
    output logic [coord_w(SPR_W*SPR_H)-1:0]   spr_rom_addr,
    input  logic [PIXEL_SIZE-1:0]             spr_rom_data,
    output logic [PIXEL_SIZE-1:0]             pixel_data,
    output logic                              pixel_valid,
    output logic                              frame_done,
    output logic                              busy,
    output logic                              overrun
);
    localparam int XW = coord_w(WIDTH);
    localparam int YW = coord_w(HEIGHT);
    localparam int AW = coord_w(SPR_W * SPR_H);
    localparam logic [XW:0] SPAN_X = (XW + 1)'(SPR_W << SCALE_LOG2);
    localparam logic [YW:0] SPAN_Y = (YW + 1)'(SPR_H << SCALE_LOG2);

    state_t state;
    logic [XW-1:0] x, sx;
    logic [YW-1:0] y, sy;
    logic [PIXEL_SIZE-1:0] bg;
    logic last, hit, accept, s1_valid, s1_hit, s1_last;
    logic [XW:0] dx;
    logic [YW:0] dy;

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
        .clk(clk),
        .rst(rst),
        .clear(state == IDLE && frame_start),
        .advance(accept),
        .x(x),
        .y(y),
        .last(last)
    );

    // one extra bit on both sides keeps edge sprites clipped instead of wrapping
    always_comb begin
        dx = {1'b0, x} - {1'b0, sx};
        dy = {1'b0, y} - {1'b0, sy};
        hit = {1'b0, x} >= {1'b0, sx} && {1'b0, x} < {1'b0, sx} + SPAN_X &&
              {1'b0, y} >= {1'b0, sy} && {1'b0, y} < {1'b0, sy} + SPAN_Y;
        spr_rom_addr = hit ? AW'(32'(dy >> SCALE_LOG2) * SPR_W + 32'(dx >> SCALE_LOG2)) : '0;
    end

    assign accept = state == ACTIVE && pixel_req && !s1_valid && !pixel_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bg <= '0;
            sx <= '0;
            sy <= '0;
            s1_valid <= 1'b0;
            s1_hit <= 1'b0;
            s1_last <= 1'b0;
            pixel_data <= '0;
            pixel_valid <= 1'b0;
            frame_done <= 1'b0;
            busy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_hit <= hit;
            s1_last <= accept && last;
            pixel_valid <= s1_valid;
            frame_done <= s1_valid && s1_last;
            if (s1_valid)
                pixel_data <= (s1_hit && spr_rom_data != TRANSPARENT) ? spr_rom_data : bg;
            if (pixel_req && state != IDLE && !accept)
                overrun <= 1'b1;
            case (state)
                IDLE: if (frame_start) begin
                    state <= ACTIVE;
                    bg <= bg_color;
                    sx <= spr_x;
                    sy <= spr_y;
                    busy <= 1'b1;
                end
                ACTIVE: if (accept && last) state <= DRAIN;
                DRAIN: if (s1_valid && s1_last) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_pixel_source.sv
// tb_sprite_pixel_source: directed frames on an 8x4 panel with a 2x2 sprite scaled by 2.
module tb_sprite_pixel_source;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic [15:0] bg_color = '0;
    logic [2:0] spr_x = '0;
    logic [1:0] spr_y = '0;
    logic pixel_req = 1'b0;
    logic [1:0] spr_rom_addr;
    logic [15:0] spr_rom_data;
    logic [15:0] pixel_data;
    logic pixel_valid, frame_done, busy, overrun;

    logic [15:0] rom [4];
    logic [15:0] cur_bg;
    int cur_sx, cur_sy;
    logic exp_ovr = 1'b0;
    int checks = 0;
    int errors = 0;

    sprite_pixel_source #(
        .WIDTH(8), .HEIGHT(4), .PIXEL_SIZE(16),
        .SPR_W(2), .SPR_H(2), .SCALE_LOG2(1), .TRANSPARENT(16'hF81F)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bg_color(bg_color),
        .spr_x(spr_x), .spr_y(spr_y), .pixel_req(pixel_req),
        .spr_rom_addr(spr_rom_addr), .spr_rom_data(spr_rom_data),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) spr_rom_data <= rom[spr_rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int x, input int y, output logic [1:0] a);
        logic h;
        h = x >= cur_sx && x < cur_sx + 4 && y >= cur_sy && y < cur_sy + 4;
        a = h ? 2'(((y - cur_sy) / 2) * 2 + (x - cur_sx) / 2) : 2'd0;
        return (h && rom[a] != 16'hF81F) ? rom[a] : cur_bg;
    endfunction

    task automatic start(input logic [15:0] bg, input int sx, input int sy);
        cur_bg = bg;
        cur_sx = sx;
        cur_sy = sy;
        bg_color = bg;
        spr_x = 3'(sx);
        spr_y = 2'(sy);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        bg_color = 16'hDEAD;
        spr_x = 3'd6;
        spr_y = 2'd3;
        check("busy_start", busy, 1);
    endtask

    task automatic do_req(input int x, input int y, input logic inj, input logic is_last);
        logic [15:0] ep;
        logic [1:0] ea;
        ep = model(x, y, ea);
        pixel_req = 1'b1;
        check($sformatf("addr(%0d,%0d)", x, y), spr_rom_addr, ea);
        tick();
        pixel_req = inj;
        check("valid_early", pixel_valid, 0);
        tick();
        pixel_req = 1'b0;
        if (inj) exp_ovr = 1'b1;
        check("valid", pixel_valid, 1);
        check($sformatf("pix(%0d,%0d)", x, y), pixel_data, ep);
        check("frame_done", frame_done, is_last);
        check("busy", busy, !is_last);
        check("overrun", overrun, exp_ovr);
        tick();
        check("valid_one", pixel_valid, 0);
        tick();
    endtask

    task automatic run_frame(input logic [15:0] bg, input int sx, input int sy, input logic inj);
        start(bg, sx, sy);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                do_req(x, y, inj && x == 0 && y == 0, x == 7 && y == 3);
        tick();
        check("done_one", frame_done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        rom = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", pixel_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_pixel", pixel_data, 0);
        check("rst_addr", spr_rom_addr, 0);
        pixel_req = 1'b1;
        tick();
        pixel_req = 1'b0;
        tick();
        tick();
        check("idle_req_valid", pixel_valid, 0);
        check("idle_req_overrun", overrun, 0);

        // sprite at (1,0): rows 0/1 read 0,0,1,1; rows 2/3 read 2,2,3,3
        run_frame(16'h001F, 1, 0, 1'b0);

        // transparent texels fall back to bg; sprite clipped at the bottom
        rom = '{16'h07E0, 16'hF81F, 16'hABCD, 16'hF81F};
        run_frame(16'h1111, 2, 2, 1'b0);

        // right-edge sprite must not wrap into column 0
        rom = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
        run_frame(16'h2222, 7, 0, 1'b0);

        // back-to-back request dropped; raster does not advance
        run_frame(16'h0F0F, 0, 0, 1'b1);

        // reset mid-frame aborts it and clears overrun
        start(16'h3333, 5, 1);
        do_req(0, 0, 1'b0, 1'b0);
        do_req(1, 0, 1'b0, 1'b0);
        pixel_req = 1'b1;
        tick();
        pixel_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ovr = 1'b0;
        check("abort_valid", pixel_valid, 0);
        check("abort_done", frame_done, 0);
        check("abort_busy", busy, 0);
        check("abort_overrun", overrun, 0);
        tick();
        check("abort_valid2", pixel_valid, 0);
        check("abort_done2", frame_done, 0);
        run_frame(16'h4444, 5, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
